// File: rtl/sgf_seq_divider_pkg.sv
// Shared FPU divider definitions: FSM state encoding, default significand width
// and the iteration-counter width helper.
package sgf_seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int SW_DEFAULT = 56;

    // The counter must hold SW itself, not just SW-1.
    function automatic int cnt_width(input int sw);
        return $clog2(sw + 1);
    endfunction

endpackage

// File: rtl/sgf_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and keep the result only if it is non-negative.
module sgf_div_step #(
    parameter int SW = 56
) (
    input  logic [SW:0]   r_in,
    input  logic          q_msb,
    input  logic [SW-1:0] b,
    output logic [SW:0]   r_out,
    output logic          q_bit
);

    logic [SW+1:0] shifted;
    logic [SW+1:0] trial;

    // The shifted remainder is below 2*B, so SW+2 bits are enough for a clean sign bit.
    always_comb begin
        shifted = {r_in, q_msb};
        trial   = shifted - {2'b00, b};
        q_bit   = ~trial[SW+1];
        r_out   = q_bit ? trial[SW:0] : shifted[SW:0];
    end

endmodule

// File: rtl/sgf_seq_divider.sv
// Sequential radix-2 restoring significand divider with start/done handshake.
// Optional macro SGF_DIV_STICKY_EN adds the sticky_o output for the rounding stage.
module sgf_seq_divider
    import sgf_seq_divider_pkg::*;
#(
    parameter int SW = SW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [SW-1:0] Data_A_i,
    input  logic [SW-1:0] Data_B_i,
    output logic          ready_o,
    output logic          done_o,
    output logic          dbz_o,
`ifdef SGF_DIV_STICKY_EN
    output logic          sticky_o,
`endif
    output logic [SW-1:0] quotient_o,
    output logic [SW-1:0] remainder_o
);

    localparam int CW = cnt_width(SW);

    div_state_t    state;
    div_state_t    state_next;
    logic [SW:0]   r_reg;
    logic [SW:0]   r_next;
    logic [SW-1:0] q_reg;
    logic [SW-1:0] q_shifted;
    logic [SW-1:0] b_reg;
    logic [CW-1:0] cnt;
    logic          q_bit;
    logic          b_zero;
    logic          last_step;

    assign b_zero    = (Data_B_i == '0);
    assign last_step = (cnt == CW'(1));
    assign q_shifted = {q_reg[SW-2:0], q_bit};
    assign ready_o   = (state == IDLE);
    assign done_o    = (state == DONE);

    sgf_div_step #(.SW(SW)) u_step (
        .r_in  (r_reg),
        .q_msb (q_reg[SW-1]),
        .b     (b_reg),
        .r_out (r_next),
        .q_bit (q_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A zero divisor skips RUN entirely so the result appears after one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = b_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reg       <= '0;
            q_reg       <= '0;
            b_reg       <= '0;
            cnt         <= '0;
            dbz_o       <= 1'b0;
            quotient_o  <= '0;
            remainder_o <= '0;
`ifdef SGF_DIV_STICKY_EN
            sticky_o    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        q_reg <= Data_A_i;
                        b_reg <= Data_B_i;
                        r_reg <= '0;
                        cnt   <= CW'(SW);
                        dbz_o <= b_zero;
                        if (b_zero) begin
                            quotient_o  <= '1;
                            remainder_o <= Data_A_i;
`ifdef SGF_DIV_STICKY_EN
                            sticky_o    <= |Data_A_i;
`endif
                        end
                    end
                end
                RUN: begin
                    r_reg <= r_next;
                    q_reg <= q_shifted;
                    cnt   <= cnt - CW'(1);
                    // Results are captured on the final step and held until overwritten.
                    if (last_step) begin
                        quotient_o  <= q_shifted;
                        remainder_o <= r_next[SW-1:0];
`ifdef SGF_DIV_STICKY_EN
                        sticky_o    <= |r_next[SW-1:0];
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
